// File: rtl/bullet_sprite_reader.sv
// Bullet sprite read engine: fetches next-line sprite rows during hblank into a
// double-buffered line buffer and maps DrawX to a registered palette index.
module bullet_sprite_reader #(
  parameter int SPR_W     = 7,
  parameter int SPR_H     = 25,
  parameter int N_BULLETS = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 5,
  parameter int X_W       = 10
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     line_start,
  input  logic [X_W-1:0]           next_y,
  input  logic [N_BULLETS-1:0]     bullet_en,
  input  logic [N_BULLETS*X_W-1:0] bullet_x,
  input  logic [N_BULLETS*X_W-1:0] bullet_y,
  output logic [ADDR_W-1:0]        read_address,
  input  logic [DATA_W-1:0]        ram_data,
  input  logic [X_W-1:0]           DrawX,
  output logic [DATA_W-1:0]        pixel_index,
  output logic                     pixel_valid,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int SW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int DW = X_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [X_W-1:0]        r_ny;
  logic [N_BULLETS-1:0]  r_en;
  logic [X_W-1:0]        r_bx [N_BULLETS];
  logic [X_W-1:0]        r_by [N_BULLETS];
  logic [SW-1:0]         r_slot;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [ADDR_W-1:0]     r_addr_hold;
  logic                  r_bank;
  logic [N_BULLETS-1:0]  r_rv  [2];
  logic [X_W-1:0]        r_lx  [2][N_BULLETS];
  logic [DATA_W-1:0]     r_buf [2][N_BULLETS][SPR_W];
  logic [DATA_W-1:0]     r_pix_idx;
  logic                  r_pix_vld;

  logic                  w_back;
  logic [DW-1:0]         w_diff;
  logic                  w_hit, w_last_col, w_last_slot;
  logic [ADDR_W-1:0]     w_addr;
  logic [DW-1:0]         w_dx   [N_BULLETS];
  logic [DATA_W-1:0]     w_word [N_BULLETS];
  logic [DATA_W-1:0]     w_pix_idx;
  logic                  w_pix_vld;

  assign w_back      = ~r_bank;
  assign w_diff      = {1'b0, r_ny} - {1'b0, r_by[r_slot]};
  assign w_hit       = r_en[r_slot] && !w_diff[X_W] && (w_diff < DW'(SPR_H));
  assign w_last_col  = (r_col == CW'(SPR_W - 1));
  assign w_last_slot = (r_slot == SW'(N_BULLETS - 1));
  assign w_addr      = ADDR_W'(r_row) * ADDR_W'(SPR_W) + ADDR_W'(r_col);

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (line_start) w_next = S_CHECK;
      S_CHECK: w_next = w_hit ? S_FETCH : (w_last_slot ? S_DONE : S_CHECK);
      S_FETCH: if (w_last_col) w_next = S_DRAIN;
      S_DRAIN: w_next = w_last_slot ? S_DONE : S_CHECK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    read_address = (r_state == S_FETCH) ? w_addr : r_addr_hold;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_bank      <= 1'b0;
      r_rv[0]     <= '0;
      r_rv[1]     <= '0;
      r_addr_hold <= '0;
      r_slot      <= '0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (line_start) begin
          r_ny   <= next_y;
          r_en   <= bullet_en;
          r_slot <= '0;
          for (int i = 0; i < N_BULLETS; i++) begin
            r_bx[i] <= bullet_x[i*X_W +: X_W];
            r_by[i] <= bullet_y[i*X_W +: X_W];
          end
        end
        S_CHECK: if (w_hit) begin
          r_row <= w_diff[RW-1:0];
          r_col <= '0;
        end else begin
          r_rv[w_back][r_slot] <= 1'b0;
          if (!w_last_slot) r_slot <= r_slot + SW'(1);
        end
        S_FETCH: begin
          r_addr_hold <= w_addr;
          r_col       <= r_col + CW'(1);
        end
        S_DRAIN: begin
          r_rv[w_back][r_slot] <= 1'b1;
          r_lx[w_back][r_slot] <= r_bx[r_slot];
          if (!w_last_slot) r_slot <= r_slot + SW'(1);
        end
        S_DONE: r_bank <= ~r_bank;
        default: ;
      endcase
    end
  end

  // RAM word for col arrives one cycle after its address; last word lands in DRAIN.
  always_ff @(posedge Clk) begin
    if (r_state == S_FETCH && r_col != '0)
      r_buf[w_back][r_slot][r_col - CW'(1)] <= ram_data;
    else if (r_state == S_DRAIN)
      r_buf[w_back][r_slot][SPR_W-1] <= ram_data;
  end

  // Walk slots high to low so the lowest contributing index is written last.
  always_comb begin
    w_pix_idx = '0;
    w_pix_vld = 1'b0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      w_dx[i]   = {1'b0, DrawX} - {1'b0, r_lx[r_bank][i]};
      w_word[i] = r_buf[r_bank][i][w_dx[i][CW-1:0]];
      if (r_rv[r_bank][i] && !w_dx[i][X_W] && (w_dx[i] < DW'(SPR_W)) && (w_word[i] != '0)) begin
        w_pix_idx = w_word[i];
        w_pix_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pix_idx <= '0;
      r_pix_vld <= 1'b0;
    end else begin
      r_pix_idx <= w_pix_idx;
      r_pix_vld <= w_pix_vld;
    end
  end

  assign pixel_index = r_pix_idx;
  assign pixel_valid = r_pix_vld;
endmodule
